// File: rtl/manchester_pkg.sv
// Shared Manchester line definitions: FSM state encoding, default timing
// constants and a 3-input majority helper used by the receive filter.
package manchester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC_HI = 2'd1,
        ST_SYNC_LO = 2'd2,
        ST_DATA    = 2'd3
    } state_t;

    localparam int unsigned DEF_HALF_BIT_LEN = 40;
    localparam int unsigned DEF_SYNC_TOL     = 12;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/manchester_rx_filter.sv
// Receive line conditioning: 2-flop synchronizer, plus a 3-sample majority
// glitch filter when MANCHESTER_RX_GLITCH_FILTER_EN is defined.
module manchester_rx_filter
    import manchester_pkg::*;
(
    input  logic clk16x,
    input  logic resetn,
    input  logic i_rx,
    output logic o_rxs
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk16x or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MANCHESTER_RX_GLITCH_FILTER_EN
    logic r_hist1;
    logic r_hist2;

    always_ff @(posedge clk16x or negedge resetn) begin
        if (!resetn) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    // A level must persist for two samples to win the vote: one cycle of delay.
    assign o_rxs = maj3(r_sync2, r_hist1, r_hist2);
`else
    assign o_rxs = r_sync2;
`endif

endmodule

// File: rtl/manchester_decoder.sv
// Manchester receiver: sync detection, mid-bit drift resync and LSB-first byte
// assembly. Optional glitch filter enabled by MANCHESTER_RX_GLITCH_FILTER_EN.
module manchester_decoder
    import manchester_pkg::*;
#(
    parameter int unsigned HALF_BIT_LEN = DEF_HALF_BIT_LEN,
    parameter int unsigned SYNC_TOL     = DEF_SYNC_TOL
) (
    input  logic       clk16x,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       decoding,
    output logic       code_err
);

    localparam int unsigned SYNC_NOM = 3 * HALF_BIT_LEN;
    localparam int unsigned SYNC_MIN = SYNC_NOM - SYNC_TOL;
    localparam int unsigned SYNC_MAX = SYNC_NOM + SYNC_TOL;
    localparam int unsigned BIT_LEN  = 2 * HALF_BIT_LEN;
    localparam int unsigned MID_MIN  = HALF_BIT_LEN - SYNC_TOL;
    localparam int unsigned MID_MAX  = HALF_BIT_LEN + SYNC_TOL;
    localparam int unsigned CNT_W    = $clog2(SYNC_MAX + 1);

    logic             w_rxs;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic             w_in_mid;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_rxs_d;
    logic             r_first;
    logic             r_second;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_decoding;
    logic             r_code_err;

    manchester_rx_filter u_rx_filter (
        .clk16x (clk16x),
        .resetn (resetn),
        .i_rx   (rx),
        .o_rxs  (w_rxs)
    );

    assign w_rise   = w_rxs & ~r_rxs_d;
    assign w_fall   = ~w_rxs & r_rxs_d;
    assign w_edge   = w_rxs ^ r_rxs_d;
    assign w_in_mid = (r_cnt >= CNT_W'(MID_MIN)) && (r_cnt <= CNT_W'(MID_MAX));

    // In SYNC_HI r_cnt+1 is the high-run length; in SYNC_LO/DATA it is cycles elapsed.
    always_ff @(posedge clk16x or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_rxs_d      <= 1'b0;
            r_first      <= 1'b0;
            r_second     <= 1'b0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_decoding   <= 1'b0;
            r_code_err   <= 1'b0;
        end else begin
            r_rxs_d      <= w_rxs;
            r_data_valid <= 1'b0;
            r_code_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state    <= ST_SYNC_HI;
                        r_cnt      <= '0;
                        r_decoding <= 1'b1;
                    end
                end
                ST_SYNC_HI: begin
                    if (w_fall) begin
                        if ((r_cnt >= CNT_W'(SYNC_MIN - 1)) && (r_cnt <= CNT_W'(SYNC_MAX - 1))) begin
                            r_state <= ST_SYNC_LO;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_state    <= ST_IDLE;
                            r_decoding <= 1'b0;
                        end
                    end else if (r_cnt >= CNT_W'(SYNC_MAX - 1)) begin
                        r_state    <= ST_IDLE;
                        r_decoding <= 1'b0;
                        r_code_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SYNC_LO: begin
                    if (w_rise && (r_cnt < CNT_W'(SYNC_MIN))) begin
                        r_state    <= ST_IDLE;
                        r_decoding <= 1'b0;
                    end else if (r_cnt == CNT_W'(SYNC_NOM - 1)) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_W'(HALF_BIT_LEN / 2)) begin
                        r_first <= w_rxs;
                    end
                    if (r_cnt == CNT_W'((3 * HALF_BIT_LEN) / 2)) begin
                        r_second <= w_rxs;
                    end
                    if (r_cnt == CNT_W'(BIT_LEN - 1)) begin
                        r_cnt <= '0;
                        if (r_first != r_second) begin
                            r_shift <= {r_second, r_shift[7:1]};
                            r_idx   <= r_idx + 3'd1;
                            if (r_idx == 3'd7) begin
                                r_data_out   <= {r_second, r_shift[7:1]};
                                r_data_valid <= 1'b1;
                            end
                        end else begin
                            // Low/low at a byte boundary is the idle line ending the frame.
                            r_state    <= ST_IDLE;
                            r_decoding <= 1'b0;
                            if ((r_idx != 3'd0) || r_first) begin
                                r_code_err <= 1'b1;
                            end
                        end
                    end else if (w_edge && w_in_mid) begin
                        r_cnt <= CNT_W'(HALF_BIT_LEN + 1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_decoding <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign decoding   = r_decoding;
    assign code_err   = r_code_err;

endmodule

// File: tb/tb_manchester_decoder.sv
// Scoreboard bench for manchester_decoder: directed frames push expected
// events; a negedge monitor pops and compares on every data_valid/code_err.
module tb_manchester_decoder;

    logic       clk16x = 1'b0;
    logic       resetn = 1'b0;
    logic       rx     = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       decoding;
    logic       code_err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    logic [7:0] last_data = 8'h00;

    manchester_decoder #(.HALF_BIT_LEN(40), .SYNC_TOL(12)) dut (
        .clk16x     (clk16x),
        .resetn     (resetn),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .decoding   (decoding),
        .code_err   (code_err)
    );

    always #5 clk16x = ~clk16x;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    task automatic push_exp(input logic is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic level(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk16x);
    endtask

    task automatic send_bit(input logic b, input int hb);
        if (b) begin
            level(1'b0, hb);
            level(1'b1, hb);
        end else begin
            level(1'b1, hb);
            level(1'b0, hb);
        end
    endtask

    task automatic send_sync(input int hb);
        level(1'b1, 3 * hb);
        level(1'b0, 3 * hb);
    endtask

    task automatic send_byte(input logic [7:0] d, input int hb);
        for (int i = 0; i < 8; i++) send_bit(d[i], hb);
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(negedge clk16x) begin
        exp_t e;
        if (resetn && (data_valid || code_err)) begin
            check("valid_err_exclusive", 32'(data_valid & code_err), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({data_valid, code_err}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    check("code_err_expected", 32'(code_err), 32'd1);
                    check("data_out_held", 32'(data_out), 32'(last_data));
                end else begin
                    check("data_valid_expected", 32'(data_valid), 32'd1);
                    check("data_out", 32'(data_out), 32'(e.data));
                    last_data = e.data;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b55;
        logic [7:0] bytes_a [4];
        logic [7:0] bytes_b [4];
        bytes_a = '{8'h12, 8'h34, 8'h56, 8'h78};
        bytes_b = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        b55     = 8'h55;

        // Reset state
        repeat (3) @(negedge clk16x);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_decoding", 32'(decoding), 32'd0);
        check("rst_code_err", 32'(code_err), 32'd0);
        resetn = 1'b1;
        level(1'b0, 20);

        // Nominal frame 0xA5
        push_exp(1'b0, 8'hA5);
        send_sync(40);
        send_byte(8'hA5, 40);
        check("decoding_in_frame", 32'(decoding), 32'd1);
        level(1'b0, 240);
        check("decoding_after_frame", 32'(decoding), 32'd0);
        check("queue_nominal", 32'(exp_q.size()), 32'd0);

        // Back-to-back bytes in one frame
        push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'hFF);
        push_exp(1'b0, 8'h3C);
        send_sync(40);
        send_byte(8'h00, 40);
        send_byte(8'hFF, 40);
        send_byte(8'h3C, 40);
        level(1'b0, 240);
        check("queue_b2b", 32'(exp_q.size()), 32'd0);

        // Short sync pulse is silently rejected
        level(1'b1, 60);
        check("decoding_short_pulse", 32'(decoding), 32'd1);
        level(1'b0, 200);
        check("idle_after_short", 32'(decoding), 32'd0);

        // Over-long sync pulse reports an error
        push_exp(1'b1, 8'h00);
        level(1'b1, 200);
        level(1'b0, 100);
        check("idle_after_long", 32'(decoding), 32'd0);
        check("queue_long", 32'(exp_q.size()), 32'd0);

        // Slow and fast transmitters
        for (int i = 0; i < 4; i++) push_exp(1'b0, bytes_a[i]);
        send_sync(37);
        for (int i = 0; i < 4; i++) send_byte(bytes_a[i], 37);
        level(1'b0, 240);
        check("queue_drift37", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) push_exp(1'b0, bytes_b[i]);
        send_sync(43);
        for (int i = 0; i < 4; i++) send_byte(bytes_b[i], 43);
        level(1'b0, 260);
        check("queue_drift43", 32'(exp_q.size()), 32'd0);

        // Bit 4 of 0x55 held high through both halves
        push_exp(1'b1, 8'h00);
        send_sync(40);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) level(1'b1, 80);
            else        send_bit(b55[i], 40);
        end
        level(1'b0, 240);
        check("data_out_after_violation", 32'(data_out), 32'hF0);
        check("queue_violation", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a byte
        send_sync(40);
        send_bit(1'b1, 40);
        send_bit(1'b0, 40);
        send_bit(1'b1, 40);
        level(1'b0, 20);
        resetn = 1'b0;
        #1;
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_decoding", 32'(decoding), 32'd0);
        check("midrst_code_err", 32'(code_err), 32'd0);
        last_data = 8'h00;
        rx = 1'b0;
        repeat (5) @(negedge clk16x);
        resetn = 1'b1;
        level(1'b0, 50);
        push_exp(1'b0, 8'hC3);
        send_sync(40);
        send_byte(8'hC3, 40);
        level(1'b0, 240);
        check("queue_after_reset", 32'(exp_q.size()), 32'd0);

        // One-cycle glitch at offset 20 of bit 2 of 0x00
`ifdef MANCHESTER_RX_GLITCH_FILTER_EN
        push_exp(1'b0, 8'h00);
`else
        push_exp(1'b1, 8'h00);
`endif
        send_sync(40);
        send_bit(1'b0, 40);
        send_bit(1'b0, 40);
        level(1'b1, 20);
        level(1'b0, 1);
        level(1'b1, 19);
        level(1'b0, 40);
        for (int i = 3; i < 8; i++) send_bit(1'b0, 40);
        level(1'b0, 240);
        check("queue_glitch", 32'(exp_q.size()), 32'd0);
        check("decoding_final", 32'(decoding), 32'd0);

        repeat (20) @(negedge clk16x);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
